// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and MEM-stage data.
// Arbitrates (data first, with a fetch starvation guard), sequences each access
// through ISSUE/WAIT, returns registered one-cycle response pulses, supports
// killing an in-flight fetch and flags memory timeouts (sticky).
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   fetch_*             fetch requester: req/addr/kill in, gnt/data/data_valid out
//   data_*              data requester: req/write/addr/wdata/mask in, gnt/rdata/done out
//   mem_*               memory port: enable/cmd/addr/write_data/mask out, load_data/valid in
//   timeout_err         sticky memory timeout flag
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 64,
    parameter logic [31:0] NOP_INST        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_kill,
    output logic        fetch_gnt,
    output logic [31:0] fetch_data,
    output logic        fetch_data_valid,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_mask,
    output logic        data_gnt,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid,
    output logic        timeout_err
);

    localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          owner_fetch;
    logic [SW-1:0] streak;
    logic [TW-1:0] tmo_cnt;
    logic          kill_flag;
    logic          force_fetch;
    logic          tmo_hit;
    logic          finish;

    // Fetch is forced once data has won MAX_DATA_STREAK times while fetch waited.
    assign force_fetch = fetch_req && (streak == SW'(MAX_DATA_STREAK));
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));
    assign finish      = (state == S_WAIT) && (mem_valid || tmo_hit);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational grants
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        data_gnt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_req && !force_fetch) begin
                    data_gnt = 1'b1;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end
                if (data_req || fetch_req) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem_valid || tmo_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted command; mem_enable strobes for the ISSUE cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_fetch    <= 1'b0;
            mem_enable     <= 1'b0;
            mem_cmd        <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_mask       <= 4'd0;
        end else begin
            mem_enable <= 1'b0;
            if (fetch_gnt) begin
                owner_fetch    <= 1'b1;
                mem_enable     <= 1'b1;
                mem_cmd        <= 1'b0;
                mem_addr       <= fetch_addr;
                mem_write_data <= 32'd0;
                mem_mask       <= 4'd0;
            end else if (data_gnt) begin
                owner_fetch    <= 1'b0;
                mem_enable     <= 1'b1;
                mem_cmd        <= data_write;
                mem_addr       <= data_addr;
                mem_write_data <= data_wdata;
                mem_mask       <= data_mask;
            end
        end
    end

    // Starvation streak and WAIT timeout counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (fetch_gnt || !fetch_req) begin
                    streak <= '0;
                end else if (data_gnt && (streak != SW'(MAX_DATA_STREAK))) begin
                    streak <= streak + SW'(1);
                end
            end
            if (state == S_ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT) && !mem_valid && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // Kill flag covers ISSUE/WAIT of a fetch and clears when the access completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_flag <= 1'b0;
        end else if (finish) begin
            kill_flag <= 1'b0;
        end else if (owner_fetch && (state != S_IDLE) && fetch_kill) begin
            kill_flag <= 1'b1;
        end
    end

    // Registered responses; a kill arriving with the final cycle still suppresses the pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_data       <= 32'd0;
            fetch_data_valid <= 1'b0;
            data_rdata       <= 32'd0;
            data_done        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            fetch_data_valid <= 1'b0;
            data_done        <= 1'b0;
            if (finish) begin
                if (owner_fetch) begin
                    if (!(kill_flag || fetch_kill)) begin
                        fetch_data_valid <= 1'b1;
                        fetch_data       <= mem_valid ? mem_load_data : NOP_INST;
                    end
                end else begin
                    data_done  <= 1'b1;
                    data_rdata <= (mem_valid && !mem_cmd) ? mem_load_data : 32'd0;
                end
                if (!mem_valid) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int          MAX_STREAK = 4;
    localparam int          TMO        = 64;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_kill;
    logic        fetch_gnt;
    logic [31:0] fetch_data;
    logic        fetch_data_valid;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mask;
    logic        data_gnt;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_enable;
    logic        mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_mask;
    logic [31:0] mem_load_data;
    logic        mem_valid;
    logic        timeout_err;

    mem_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_kill       (fetch_kill),
        .fetch_gnt        (fetch_gnt),
        .fetch_data       (fetch_data),
        .fetch_data_valid (fetch_data_valid),
        .data_req         (data_req),
        .data_write       (data_write),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_mask        (data_mask),
        .data_gnt         (data_gnt),
        .data_rdata       (data_rdata),
        .data_done        (data_done),
        .mem_enable       (mem_enable),
        .mem_cmd          (mem_cmd),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_mask         (mem_mask),
        .mem_load_data    (mem_load_data),
        .mem_valid        (mem_valid),
        .timeout_err      (timeout_err)
    );

    // Expected response: cycle it must appear in, {fetch_valid,data_done}, data, timeout_err
    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [31:0] data;
        logic        terr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   streak_m = 0;
    bit   terr_m   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor / scoreboard
    initial begin
        exp_t e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (fetch_data_valid || data_done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got fv=%0b dd=%0b expected none (cycle %0d)",
                             fetch_data_valid, data_done, cyc);
                end else begin
                    e = sb.pop_front();
                    got = e.kind[1] ? fetch_data : data_rdata;
                    check("response", 128'({32'(cyc), fetch_data_valid, data_done, got, timeout_err}),
                          128'({e.cyc, e.kind, e.data, e.terr}));
                end
            end else if (sb.size() > 0 && int'(sb[0].cyc) < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_pulse: got none expected pulse at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    // One transaction from an IDLE negedge; lat<0 means memory never answers.
    // kill_at: 0 = ISSUE cycle, k = WAIT cycle k-1; negative = no kill.
    task automatic run_txn(input bit f, input bit d, input bit wr,
                           input logic [31:0] faddr, input logic [31:0] daddr,
                           input logic [31:0] wd, input logic [3:0] mk,
                           input int lat, input int kill_at, input int gap,
                           input bit use_rd, input logic [31:0] rdv, input string tag);
        bit          wf;
        bit          killed;
        int          nwait;
        logic [31:0] rd;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  em;
        logic        ecmd;
        exp_t        e;
        rd = 32'd0;
        fetch_req  = f;
        fetch_addr = faddr;
        data_req   = d;
        data_write = wr;
        data_addr  = daddr;
        data_wdata = wd;
        data_mask  = mk;
        // Data first unless fetch has been passed over MAX_STREAK times
        wf = f && !(d && streak_m != MAX_STREAK);
        #1 check({tag, "_gnt"}, 128'({fetch_gnt, data_gnt}), 128'(wf ? 2'b10 : 2'b01));
        if (wf) streak_m = 0;
        else if (f) streak_m = (streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK;
        else streak_m = 0;
        ecmd = wf ? 1'b0 : wr;
        ea   = wf ? faddr : daddr;
        em   = wf ? 4'b0000 : mk;
        ewd  = wf ? 32'd0 : wd;

        @(negedge clk);
        fetch_req     = 1'b0;
        data_req      = 1'b0;
        fetch_addr    = $urandom;
        data_addr     = $urandom;
        data_wdata    = $urandom;
        data_mask     = 4'($urandom);
        data_write    = 1'($urandom);
        fetch_kill    = (kill_at == 0);
        mem_valid     = ($urandom % 4 == 0);
        mem_load_data = $urandom;
        check({tag, "_issue"},
              128'({mem_enable, mem_cmd, mem_addr, mem_mask, (wf ? 32'd0 : mem_write_data)}),
              128'({1'b1, ecmd, ea, em, ewd}));

        nwait = (lat < 0) ? TMO : lat + 1;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            fetch_kill    = (kill_at == i + 1);
            rd            = (use_rd && i == lat) ? rdv : $urandom;
            mem_load_data = rd;
            mem_valid     = (lat >= 0 && i == lat);
            if (i == 0) begin
                check({tag, "_wait"}, 128'({mem_enable, mem_cmd, mem_addr, mem_mask}),
                      128'({1'b0, ecmd, ea, em}));
            end
        end

        killed = wf && kill_at >= 0 && kill_at <= nwait;
        if (lat < 0) terr_m = 1'b1;
        if (!killed) begin
            e.cyc  = 32'(cyc + 1);
            e.kind = wf ? 2'b10 : 2'b01;
            if (wf) e.data = (lat < 0) ? NOP : rd;
            else    e.data = (lat < 0 || wr) ? 32'd0 : rd;
            e.terr = terr_m;
            sb.push_back(e);
        end

        // Response cycle (IDLE): stray mem_valid / fetch_kill must be ignored
        @(negedge clk);
        mem_valid  = ($urandom % 3 == 0);
        fetch_kill = ($urandom % 4 == 0);
        mem_load_data = $urandom;
        if (gap > 0) streak_m = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            mem_valid  = ($urandom % 3 == 0);
            fetch_kill = ($urandom % 4 == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        bit d;
        int r;
        int lat;
        int kat;
        rst = 1'b0;
        fetch_req = 0; fetch_addr = 0; fetch_kill = 0;
        data_req = 0; data_write = 0; data_addr = 0; data_wdata = 0; data_mask = 0;
        mem_load_data = 0; mem_valid = 0;
        repeat (2) @(negedge clk);
        #1 check("reset_state",
                 128'({fetch_gnt, data_gnt, fetch_data, fetch_data_valid, data_rdata, data_done,
                       mem_enable, mem_cmd, mem_addr, mem_write_data, mem_mask, timeout_err}),
                 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch, minimum latency
        run_txn(1, 0, 0, 32'h100, 0, 0, 0, 0, -1, 1, 1, 32'h0050_0093, "fetch1");

        // Contention: data x4, then forced fetch, then data
        for (int k = 0; k < 6; k++)
            run_txn(1, 1, 0, 32'h200 + 32'(4 * k), 32'h1000 + 32'(4 * k), 0, 4'hf, 0, -1, 0, 0, 0, "streak");
        repeat (1) @(negedge clk);
        streak_m = 0;

        // Store
        run_txn(0, 1, 1, 0, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1, -1, 1, 0, 0, "store");

        // Killed fetch, then a normal fetch
        run_txn(1, 0, 0, 32'h100, 0, 0, 0, 2, 1, 0, 0, 0, "kill");
        run_txn(1, 0, 0, 32'h104, 0, 0, 0, 0, -1, 1, 0, 0, "after_kill");

        // Timeout on a load, then normal service
        run_txn(0, 1, 0, 0, 32'h3000, 0, 4'hf, -1, -1, 1, 0, 0, "timeout");
        run_txn(0, 1, 0, 0, 32'h3004, 0, 4'hf, 0, -1, 1, 0, 0, "after_tmo");

        // Async reset while in WAIT
        fetch_req = 1'b1; fetch_addr = 32'h300; mem_valid = 1'b0; fetch_kill = 1'b0;
        #1 check("rst_gnt", 128'({fetch_gnt, data_gnt}), 128'(2'b10));
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_async",
                 128'({fetch_gnt, data_gnt, fetch_data, fetch_data_valid, data_rdata, data_done,
                       mem_enable, mem_cmd, mem_addr, mem_write_data, mem_mask, timeout_err}),
                 128'(0));
        streak_m = 0;
        terr_m   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_load_data = 32'h1234_5678;
        @(negedge clk);
        mem_valid = 1'b0;
        check("rst_nopulse", 128'({fetch_data_valid, data_done}), 128'(0));
        @(negedge clk);
        run_txn(1, 0, 0, 32'h400, 0, 0, 0, 0, -1, 1, 0, 0, "post_rst");

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            r   = $urandom % 3;
            f   = (r != 1);
            d   = (r != 0);
            lat = ($urandom % 16 == 0) ? -1 : int'($urandom % 4);
            kat = (f && $urandom % 3 == 0) ? int'($urandom_range(0, (lat < 0) ? TMO : lat + 1)) : -1;
            run_txn(f, d, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
                    lat, kat, int'($urandom % 3), 0, 0, "rand");
        end

        mem_valid  = 1'b0;
        fetch_kill = 1'b0;
        repeat (4) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'(0));
        check("terr_final", 128'(timeout_err), 128'(terr_m));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
